// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame layout and bit-period helper.
// Latency: none (types and constants only).
// Backpressure: none; the transmitter and a future receiver both import this.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } tx_state_t;

    // start + 8 data + stop
    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // Clock cycles per serial bit, integer-truncated.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts while enabled, flags the last cycle of each bit period.
// Latency: tick is combinational from the count, high in cycle SYMBOL_EDGE_TIME-1 of a period.
// Backpressure: none; clr holds the count at zero so a new bit period starts cleanly.
module uart_baud_tick #(
    parameter int SYMBOL_EDGE_TIME = 1085,
    parameter int CNT_WIDTH        = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(SYMBOL_EDGE_TIME - 1);

    logic [CNT_WIDTH-1:0] cnt;

    // Count 0..LAST and fold back to zero on the boundary; never runs past LAST.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a transmit FIFO one byte at a time and sends each byte as an 8N1 UART frame.
// Latency: fifo_empty low seen in IDLE at t -> pop at t+1 -> start bit on the line from t+3.
// Backpressure: pops only from IDLE when not empty; fifo_empty is ignored while a frame is in flight.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ       = 125_000_000,
    parameter int BAUD_RATE        = 115_200,
    parameter int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE),
    parameter int CNT_WIDTH        = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_dout,
    output logic       serial_out,
    output logic       tx_busy
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    tx_state_t             state;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  baud_tick;

    // The bit timer only runs in SEND; every other state parks it at zero so the
    // start bit loaded in LOAD gets a full period.
    uart_baud_tick #(
        .SYMBOL_EDGE_TIME (SYMBOL_EDGE_TIME),
        .CNT_WIDTH        (CNT_WIDTH)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != SEND),
        .en   (state == SEND),
        .tick (baud_tick)
    );

    // Frame sequencer: pop, capture the byte a cycle later, then shift it out LSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= STOP_BIT;
            bit_cnt    <= '0;
            shreg      <= '1;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= STOP_BIT;
                    if (!fifo_empty) begin
                        state <= FETCH;
                    end
                end
                // Pop is decoded from this state; read data arrives next cycle.
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg      <= {STOP_BIT, fifo_dout, START_BIT};
                    serial_out <= START_BIT;
                    bit_cnt    <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            // Stop bit has had its full period; back to idle-high.
                            serial_out <= STOP_BIT;
                            bit_cnt    <= '0;
                            shreg      <= '1;
                            state      <= IDLE;
                        end else begin
                            shreg      <= {1'b1, shreg[FRAME_BITS-1:1]};
                            serial_out <= shreg[1];
                            bit_cnt    <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = (state == FETCH);
    assign tx_busy    = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a depth-32 registered-read FIFO model in front of it.
// Stimulus pushes expected bytes into a queue; a line monitor decodes frames and compares.
// Bit period is 10 cycles (CLOCK_FREQ=1000, BAUD_RATE=100).
module tb_fifo_uart_tx;

    localparam int BIT_CYC   = 10;
    localparam int FRAME_CYC = 10 * BIT_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       serial_out;
    logic       tx_busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .serial_out (serial_out),
        .tx_busy    (tx_busy)
    );

    // ---------------- FIFO model: depth 32, dout registered on pop ----------------
    logic [7:0] mem [32];
    int         wptr = 0;
    int         rptr = 0;
    int         count = 0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_dat = 8'h00;

    assign fifo_empty = (count == 0);

    always @(posedge clk) begin
        if (wr_en && count < 32) begin
            mem[wptr] <= wr_dat;
            wptr      <= (wptr + 1) % 32;
        end
        if (fifo_rd_en && count > 0) begin
            fifo_dout <= mem[rptr];
            rptr      <= (rptr + 1) % 32;
        end
        count <= count + ((wr_en && count < 32) ? 1 : 0) - ((fifo_rd_en && count > 0) ? 1 : 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- line monitor: decode frames from serial_out ----------------
    bit         in_frame     = 1'b0;
    bit         prev_end_vld = 1'b0;
    int         fcyc         = 0;
    int         timing_err   = 0;
    int         prev_end     = 0;
    int         last_gap     = -1;
    int         frames       = 0;
    logic [7:0] cur_exp      = 8'h00;
    logic [7:0] got_byte     = 8'h00;

    initial begin : monitor
        int   bi;
        logic expbit;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame     = 1'b0;
                prev_end_vld = 1'b0;
            end else begin
                if (!in_frame && serial_out === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_frame", 1, 0);
                        cur_exp = 8'h00;
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                    last_gap   = prev_end_vld ? (cyc - prev_end) : -1;
                    in_frame   = 1'b1;
                    fcyc       = 0;
                    timing_err = 0;
                    got_byte   = 8'h00;
                end
                if (in_frame) begin
                    if (fcyc < FRAME_CYC) begin
                        bi = fcyc / BIT_CYC;
                        if (bi == 0)      expbit = 1'b0;
                        else if (bi == 9) expbit = 1'b1;
                        else              expbit = cur_exp[bi-1];
                        if (serial_out !== expbit || tx_busy !== 1'b1) timing_err++;
                        if ((fcyc % BIT_CYC) == BIT_CYC / 2 && bi >= 1 && bi <= 8)
                            got_byte[bi-1] = serial_out;
                        fcyc++;
                    end else begin
                        chk("frame_byte", got_byte, cur_exp);
                        chk("frame_bit_timing_errors", timing_err, 0);
                        chk("frame_end_idle", {serial_out, tx_busy}, 2'b10);
                        in_frame     = 1'b0;
                        prev_end     = cyc;
                        prev_end_vld = 1'b1;
                        frames++;
                    end
                end
            end
        end
    end

    // ---------------- pop checker: one-cycle pulses, never on an empty FIFO ----------------
    int rd_cnt  = 0;
    bit prev_rd = 1'b0;

    initial begin : rd_checker
        forever begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) begin
                rd_cnt++;
                chk("rd_en_pulse_empty_or_repeat", {fifo_empty, prev_rd}, 0);
            end
            prev_rd = (fifo_rd_en === 1'b1);
        end
    end

    // ---------------- stimulus helpers (drive at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en  = 1'b1;
        wr_dat = b;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        bit done = 1'b0;
        for (int n = 0; n < limit && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_frame && fifo_empty && tx_busy === 1'b0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : stim
        int r0, f0, t_e, t_r, t_s;
        bit found;

        // Reset state
        tick(2);
        @(negedge clk);
        chk("reset_outputs", {serial_out, fifo_rd_en, tx_busy}, 3'b100);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Empty FIFO for 500 cycles: line idle, no pops, not busy
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            chk("idle_lines", {serial_out, fifo_rd_en, tx_busy}, 3'b100);
        end
        @(posedge clk);
        #1;

        // Single byte 0xA5 with latency measurement
        r0 = rd_cnt; f0 = frames;
        wr(8'hA5);
        t_e = -1; t_r = -1; t_s = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t_e < 0 && fifo_empty === 1'b0) t_e = cyc;
            if (t_r < 0 && fifo_rd_en === 1'b1) t_r = cyc;
            if (t_s < 0 && serial_out === 1'b0) t_s = cyc;
        end
        chk("t1_rd_en_latency", t_r - t_e, 1);
        chk("t1_start_latency", t_s - t_e, 3);
        @(posedge clk);
        #1;
        wait_drain(400);
        chk("t1_pops", rd_cnt - r0, 1);
        chk("t1_frames", frames - f0, 1);

        // Back-to-back 0x00, 0xFF
        r0 = rd_cnt; f0 = frames; last_gap = -1;
        wr(8'h00);
        wr(8'hFF);
        wait_drain(600);
        chk("t2_pops", rd_cnt - r0, 2);
        chk("t2_frames", frames - f0, 2);
        chk("t2_gap", last_gap, 3);
        chk("t2_fifo_empty", fifo_empty, 1);

        // Reset during data bit 3 of 0x3C
        f0 = frames;
        wr(8'h3C);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (in_frame && fcyc == 45) found = 1'b1;
        end
        chk("t4_reached_bit3", found, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_after_reset", {serial_out, tx_busy}, 2'b10);
        r0 = rd_cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) chk("t4_line_high", serial_out, 1);
        end
        chk("t4_no_pops", rd_cnt - r0, 0);
        chk("t4_no_frame_completed", frames - f0, 0);
        @(posedge clk);
        #1;

        // Write during SEND: 0x22 in flight, 0x11 pushed mid-frame
        r0 = rd_cnt; f0 = frames; last_gap = -1;
        wr(8'h22);
        tick(40);
        chk("t5_busy_midframe", tx_busy, 1);
        wr(8'h11);
        wait_drain(600);
        chk("t5_pops", rd_cnt - r0, 2);
        chk("t5_frames", frames - f0, 2);
        chk("t5_gap", last_gap, 3);

        // Burst of 32 bytes loaded while the transmitter is held in reset
        rst = 1'b1;
        for (int i = 0; i < 32; i++) wr(8'(i));
        chk("t6_fifo_full", count, 32);
        r0 = rd_cnt; f0 = frames; last_gap = -1;
        rst = 1'b0;
        wait_drain(32 * (FRAME_CYC + 3) + 200);
        chk("t6_pops", rd_cnt - r0, 32);
        chk("t6_frames", frames - f0, 32);
        chk("t6_gap", last_gap, 3);
        chk("t6_idle_after", {serial_out, tx_busy, fifo_empty}, 3'b101);

        // A few random bytes to exercise arbitrary patterns
        r0 = rd_cnt; f0 = frames;
        for (int i = 0; i < 6; i++) begin
            wr(8'($urandom_range(0, 255)));
            tick($urandom_range(0, 150));
        end
        wait_drain(2000);
        chk("rand_pops", rd_cnt - r0, 6);
        chk("rand_frames", frames - f0, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Drain stage downstream of the I/O transmit FIFO. Pops bytes from the FIFO read port and serialises each as an 8N1 UART frame on the serial TX line: start bit 0, 8 data bits LSB first, stop bit 1. It runs one pop at a time and tolerates the FIFO's one-cycle registered read latency. The line idles high whenever the FIFO is empty.

Parameters:
CLOCK_FREQ, 125_000_000, system clock frequency in Hz.
BAUD_RATE, 115_200, serial bit rate.
SYMBOL_EDGE_TIME, CLOCK_FREQ/BAUD_RATE (integer truncation, 1085 at defaults), clock cycles per bit. Overridable for simulation.
CNT_WIDTH, $clog2(SYMBOL_EDGE_TIME), baud counter width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  pop request to the FIFO; high for exactly one cycle per byte.
fifo_dout  input  8  FIFO read data; valid the cycle after the cycle in which fifo_rd_en is high.
serial_out  output  1  UART TX line; registered output, idle high.
tx_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (clk, rst synchronous active-high): state=IDLE, serial_out=1, fifo_rd_en=0, tx_busy=0, baud and bit counters=0, shift register=all ones.
- FSM states: IDLE, FETCH, LOAD, SEND.
- IDLE: serial_out=1. If !fifo_empty, go to FETCH next edge. Otherwise stay in IDLE.
- FETCH: fifo_rd_en=1 (decoded from state, this cycle only). Unconditionally go to LOAD.
- LOAD: capture fifo_dout into a 10-bit shift register {1'b1, data[7:0], 1'b0}. At the same edge: serial_out<=0 (start bit), baud_cnt<=0, bit_cnt<=0, state->SEND.
- SEND, baud_cnt below SYMBOL_EDGE_TIME-1: baud_cnt increments.
- SEND, baud_cnt reaches SYMBOL_EDGE_TIME-1 (bit boundary): baud_cnt<=0, shift right, bit_cnt++, serial_out<=next bit.
- SEND, after bit_cnt 9 (stop bit) completes: serial_out<=1, state->IDLE.
- Bit timing: every bit, stop bit included, is held for exactly SYMBOL_EDGE_TIME cycles. One frame = 10*SYMBOL_EDGE_TIME cycles.
- Latency: fifo_empty low sampled in IDLE at cycle t -> fifo_rd_en high in t+1 -> serial_out low from t+3.
- Back-to-back bytes: the line stays high for 3 cycles between a stop bit and the next start bit (IDLE, FETCH, LOAD). This is legal extended stop time.
- fifo_empty is ignored outside IDLE. FIFO writes during SEND do not affect the frame in flight.
- Exactly one pop per frame. fifo_rd_en is never asserted while fifo_empty=1.
- rst mid-frame: next cycle serial_out=1 and state=IDLE. The popped byte is discarded and not retransmitted.
- Counters never exceed their terminal values. There are no arithmetic wrap paths.

Decomposition:
- Shared package uart_pkg: state encoding (IDLE/FETCH/LOAD/SEND), FRAME_BITS=10, START_BIT=0, STOP_BIT=1, SYMBOL_EDGE_TIME computation. A future uart_rx reuses this package.
- One natural sub-module: uart_baud_tick. It is a counter with synchronous clear and enable, and it emits a one-cycle tick at SYMBOL_EDGE_TIME-1. The FSM, shift register and FIFO handshake stay in fifo_uart_tx.

Test Plan:
(Bench uses CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL_EDGE_TIME=10. A FIFO model has depth 32 and registered dout.)
1. Single byte: write 0xA5, fifo_empty falls at t.
   - fifo_rd_en is high only at t+1; serial_out low from t+3.
   - Line sampled every 10 cycles reads 0,1,0,1,0,0,1,0,1,1.
   - tx_busy drops after 100 frame cycles.
2. Back-to-back: write 0x00 then 0xFF.
   - Two frames with exactly 3 high cycles between the stop bit and the second start bit.
   - Exactly two fifo_rd_en pulses; FIFO empty afterwards.
3. Empty FIFO after reset for 500 cycles: serial_out=1, fifo_rd_en=0, tx_busy=0 every cycle.
4. Reset mid-frame: pulse rst during data bit 3 of 0x3C.
   - serial_out=1 and tx_busy=0 the following cycle.
   - No further pops while the FIFO stays empty.
5. Writes during SEND: push 0x11 while 0x22 is transmitting.
   - 0x22 frame is unaltered; 0x11 follows with the 3-cycle gap.
   - Never more than one rd_en per frame.
6. Burst of 32 bytes, 0x00..0x1F (FIFO filled to full).
   - 32 frames in order, 32 rd_en pulses.
   - fifo_rd_en never high while fifo_empty=1.
